game_controller: RTL

Game-state sequencer that sits directly upstream of the VGA renderer. It debounces the raw board buttons and runs the top-level game FSM. It drives the renderer's one-hot `status` and `direction` inputs and a frame-based score counter. The collision detector and the vsync-derived frame pulse feed back into it.

---
 rtl/game_controller.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/game_controller.sv
// Top-level game sequencer: debounces six board buttons and runs the game FSM
// that drives the renderer's one-hot status/direction and a frame-based score.
module game_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned SPLASH_FRAMES   = 120,
  parameter int unsigned SCORE_MAX       = 9999
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        btn_start,
  input  logic        btn_pause,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        frame_tick,
  input  logic        collision,
  output logic [3:0]  status,
  output logic [3:0]  direction,
  output logic [13:0] score
);

  localparam int unsigned NB  = 6;
  localparam int unsigned DCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned SCW = (SPLASH_FRAMES > 0) ? $clog2(SPLASH_FRAMES + 1) : 1;
  localparam logic [DCW-1:0] DB_LAST    = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SCW-1:0] SPLASH_LIM = SCW'(SPLASH_FRAMES);
  localparam logic [13:0]    SCORE_LIM  = 14'(SCORE_MAX);

  localparam int unsigned B_START = 0;
  localparam int unsigned B_PAUSE = 1;
  localparam int unsigned B_UP    = 2;
  localparam int unsigned B_DOWN  = 3;
  localparam int unsigned B_LEFT  = 4;
  localparam int unsigned B_RIGHT = 5;

  // State encodings double as the registered one-hot status value.
  typedef enum logic [3:0] {
    ST_NONE      = 4'b0000,
    ST_LOAD      = 4'b1000,
    ST_ACTIVATE  = 4'b0100,
    ST_PAUSE     = 4'b0010,
    ST_TERMINATE = 4'b0001
  } state_t;

  logic [NB-1:0]  raw;
  logic [NB-1:0]  s1_q, s2_q;
  logic [NB-1:0]  db_q, db_d, dbd_q;
  logic [DCW-1:0] cnt_q [NB];
  logic [DCW-1:0] cnt_d [NB];
  logic [NB-1:0]  press;

  state_t         state_q, state_d;
  logic [SCW-1:0] splash_q, splash_d;
  logic [3:0]     dir_q, dir_d;
  logic [13:0]    score_q, score_d;

  assign raw   = {btn_right, btn_left, btn_down, btn_up, btn_pause, btn_start};
  assign press = db_q & ~dbd_q;

  always_comb begin
    db_d = db_q;
    for (int unsigned i = 0; i < NB; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DB_LAST) db_d[i] = s2_q[i];
        else                     cnt_d[i] = cnt_q[i] + DCW'(1);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    splash_d = splash_q;
    dir_d    = dir_q;
    score_d  = score_q;
    case (state_q)
      ST_NONE: begin
        if (splash_q == SPLASH_LIM) begin
          state_d  = ST_LOAD;
          splash_d = '0;
        end else if (frame_tick) begin
          splash_d = splash_q + SCW'(1);
        end
      end
      ST_LOAD: begin
        if (press[B_START]) begin
          state_d = ST_ACTIVATE;
          score_d = '0;
          dir_d   = '0;
        end
      end
      ST_ACTIVATE: begin
        if (collision)           state_d = ST_TERMINATE;
        else if (press[B_PAUSE]) state_d = ST_PAUSE;
        if (press[B_UP])         dir_d = 4'b1000;
        else if (press[B_DOWN])  dir_d = 4'b0100;
        else if (press[B_LEFT])  dir_d = 4'b0010;
        else if (press[B_RIGHT]) dir_d = 4'b0001;
        if (frame_tick && (score_q < SCORE_LIM)) score_d = score_q + 14'd1;
      end
      ST_PAUSE: begin
        if (press[B_PAUSE]) state_d = ST_ACTIVATE;
      end
      ST_TERMINATE: begin
        if (press[B_START]) state_d = ST_LOAD;
      end
      default: state_d = ST_NONE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      s1_q     <= '0;
      s2_q     <= '0;
      db_q     <= '0;
      dbd_q    <= '0;
      for (int unsigned i = 0; i < NB; i++) cnt_q[i] <= '0;
      state_q  <= ST_NONE;
      splash_q <= '0;
      dir_q    <= '0;
      score_q  <= '0;
    end else begin
      s1_q     <= raw;
      s2_q     <= s1_q;
      db_q     <= db_d;
      dbd_q    <= db_q;
      for (int unsigned i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
      state_q  <= state_d;
      splash_q <= splash_d;
      dir_q    <= dir_d;
      score_q  <= score_d;
    end
  end

  assign status    = state_q;
  assign direction = dir_q;
  assign score     = score_q;

endmodule
